// File: rtl/note_entry_ctrl.sv
// note_entry_ctrl: debounced note/octave entry for the glyph drawer.
// Emits a throttled ld_note strobe and walks a slot grid on screen.
module note_entry_ctrl #(
  parameter int DEBOUNCE = 50000,
  parameter int HOLD     = 1024,
  parameter int X0       = 4,
  parameter int Y0       = 4,
  parameter int SLOT_W   = 36,
  parameter int SLOT_H   = 16,
  parameter int COLS     = 4,
  parameter int ROWS     = 7
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [11:0] key_note,
  input  logic        oct_up,
  input  logic        oct_down,
  input  logic [2:0]  colour_sw,
  output logic [3:0]  note,
  output logic [1:0]  octave,
  output logic        ld_note,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour_in,
  output logic        busy
);

  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int HW = $clog2(HOLD + 1);
  localparam int CW = $clog2(COLS + 1);
  localparam int RW = $clog2(ROWS + 1);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);

  localparam int X_MAX = X0 + (COLS - 1) * SLOT_W + 35;
  localparam int Y_MAX = Y0 + (ROWS - 1) * SLOT_H + 11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PULSE,
    S_HOLD,
    S_ADV
  } state_t;

  state_t        state;
  logic [13:0]   raw;
  logic [13:0]   sync1;
  logic [13:0]   sync2;
  logic [13:0]   db;
  logic [13:0]   db_prev;
  logic [13:0]   rise;
  logic [DW-1:0] cnt [14];
  logic [2:0]    col_s1;
  logic [2:0]    col_s2;
  logic [1:0]    oct_sel;
  logic          armed;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [HW-1:0] hold_cnt;
  logic          key_any;
  logic [3:0]    key_idx;
  logic [7:0]    x_slot;
  logic [6:0]    y_slot;

  assign raw  = {oct_down, oct_up, key_note};
  assign rise = db & ~db_prev;

  // two-flop synchronizers for buttons and colour switches
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1   <= '0;
      sync2   <= '0;
      col_s1  <= '0;
      col_s2  <= '0;
      db_prev <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      col_s1  <= colour_sw;
      col_s2  <= col_s1;
      db_prev <= db;
    end
  end

  // per-button debounce: level flips after DEBOUNCE stable cycles
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      db <= '0;
      for (int i = 0; i < 14; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 14; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          cnt[i] <= '0;
          db[i]  <= sync2[i];
        end else begin
          cnt[i] <= cnt[i] + DW'(1);
        end
      end
    end
  end

  // lowest pressed key wins; slot origin from grid position
  always_comb begin
    key_any = |db[11:0];
    key_idx = '0;
    for (int i = 11; i >= 0; i--) begin
      if (db[i]) key_idx = 4'(i);
    end
    x_slot = 8'(X0 + int'(col) * SLOT_W);
    y_slot = 7'(Y0 + int'(row) * SLOT_H);
  end

  // saturating octave selector, simultaneous up/down cancels
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      oct_sel <= '0;
    end else if (rise[12] && !rise[13]) begin
      if (oct_sel != 2'd3) oct_sel <= oct_sel + 2'd1;
    end else if (rise[13] && !rise[12]) begin
      if (oct_sel != 2'd0) oct_sel <= oct_sel - 2'd1;
    end
  end

  // accept / load / strobe / hold / advance sequencer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      armed     <= 1'b1;
      col       <= '0;
      row       <= '0;
      hold_cnt  <= '0;
      note      <= '0;
      octave    <= '0;
      ld_note   <= 1'b0;
      x         <= 8'(X0);
      y         <= 7'(Y0);
      colour_in <= '0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (armed && key_any) begin
            armed     <= 1'b0;
            note      <= key_idx + 4'd1;
            octave    <= oct_sel;
            colour_in <= col_s2;
            x         <= x_slot;
            y         <= y_slot;
            busy      <= 1'b1;
            state     <= S_LOAD;
          end else if (!key_any) begin
            armed <= 1'b1;
          end
        end
        S_LOAD: begin
          ld_note <= 1'b1;
          state   <= S_PULSE;
        end
        S_PULSE: begin
          ld_note  <= 1'b0;
          hold_cnt <= '0;
          state    <= S_HOLD;
        end
        S_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state <= S_ADV;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        S_ADV: begin
          if (col == COL_LAST) begin
            col <= '0;
            if (row == ROW_LAST) row <= '0;
            else row <= row + RW'(1);
          end else begin
            col <= col + CW'(1);
          end
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // grid must fit the 160x120 frame
  always @(posedge clk) begin
    assert (X_MAX <= 159 && Y_MAX <= 119)
      else $error("slot grid exceeds frame");
  end

endmodule
